regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port general-purpose register file for the decode stage. Next generation of the 2R/1W file:
//  - configurable width, depth and read-port count
//  - two write ports with write-through bypass
//  - per-register pending-write scoreboard for hazard detection
//  - sequenced bulk-clear engine that zeroes the file one entry per cycle
// PARAMETERS
//  DW     32  data width of each register
//  AW     5   address width; DEPTH = 2**AW registers
//  NR     2   number of read ports (1..8)
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      asynchronous, active-high reset
//  we0          in   1      write enable, port 0
//  waddr0       in   AW     write address, port 0
//  wdata0       in   DW     write data, port 0
//  we1          in   1      write enable, port 1 (priority port)
//  waddr1       in   AW     write address, port 1
//  wdata1       in   DW     write data, port 1
//  re           in   NR     read enable, one bit per read port
//  raddr        in   NR*AW  read addresses, port i at [i*AW +: AW]
//  rdata        out  NR*DW  read data, port i at [i*DW +: DW]
//  rbusy        out  NR     register at raddr[i] has a pending producer
//  sb_set       in   1      mark sb_addr as pending (instruction issued)
//  sb_addr      in   AW     scoreboard set address
//  clr_req      in   1      start bulk clear
//  clr_busy     out  1      bulk clear in progress
//  clr_done     out  1      one-cycle pulse when bulk clear finishes
// BEHAVIOUR
//  Reset (async, rst=1):
//  - all registers and busy bits = 0; FSM = IDLE; clr_busy = 0, clr_done = 0
//  - rdata and rbusy forced to 0 combinationally while rst = 1
//  Register 0:
//  - always reads 0 and is never busy
//  - writes and sb_set to address 0 are ignored
//  Writes:
//  - registered at posedge when weN = 1 and FSM = IDLE
//  - both ports, same address: port 1 data stored
//  Reads (combinational, zero latency), per port i, in priority order:
//  - re[i] = 0 or raddr = 0 -> 0
//  - FSM = IDLE and we1 && waddr1 == raddr -> wdata1
//  - FSM = IDLE and we0 && waddr0 == raddr -> wdata0
//  - otherwise -> stored value
//  Scoreboard:
//  - an effective write on either port clears busy[waddr] at posedge
//  - sb_set sets busy[sb_addr] at posedge
//  - set and clear of the same address in the same cycle: set wins (new producer)
//  - rbusy[i] = re[i] && raddr != 0 && busy[raddr] && no same-cycle effective write to raddr (bypass covers it)
//  Bulk-clear FSM, states IDLE -> SWEEP -> DONE -> IDLE:
//  - IDLE: clr_req = 1 -> SWEEP, counter = 1
//  - SWEEP: each cycle zero regs[counter] and busy[counter], counter++
//    - leave SWEEP after counter = DEPTH-1 is zeroed; lasts DEPTH-1 cycles
//    - clr_busy = 1 (registered output)
//    - we0/we1/sb_set ignored; bypass disabled; reads return stored values
//    - clr_req ignored
//  - DONE: clr_done = 1 for exactly one cycle, then IDLE; writes accepted again from the IDLE cycle
//  - rst mid-sweep: immediate return to IDLE, all state zeroed
// TESTING
//  1. Write x5=0xDEADBEEF via port 0, next cycle read on ports 0,1 -> both 0xDEADBEEF; write x0=0x1234, read x0 -> 0.
//  2. Same cycle we0 x7=0x11, we1 x7=0x22, read x7 -> bypass 0x22; next cycle stored value 0x22.
//  3. sb_set x3; next cycle read x3 -> rbusy=1; write x3=0x55 -> rbusy=0 and rdata=0x55 that cycle; busy clear after.
//  4. sb_set x4 and we0 x4 in the same cycle -> busy[x4]=1 afterwards.
//  5. Fill regs with index value, pulse clr_req -> clr_busy high 31 cycles (DEPTH=32), writes ignored during sweep, clr_done pulses once, all reads 0.
//  6. Assert rst asynchronously mid-sweep (between clock edges) -> clr_busy, rdata, rbusy drop to 0 immediately; after release FSM in IDLE, writes accepted.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational read ports, two write ports with
// write-through bypass, per-register pending-producer scoreboard and a bulk-clear sweep.
module regfile_mp #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [DW-1:0]    wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [DW-1:0]    wdata1,
    input  logic [NR-1:0]    re,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [1:0]       dbg_state
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt;
    logic [DW-1:0]   regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic            idle, sweep;
    logic            wr0, wr1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = SWEEP;
            SWEEP:   if (cnt == {AW{1'b1}}) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idle      = (state == IDLE);
        sweep     = (state == SWEEP);
        clr_busy  = sweep;
        clr_done  = (state == DONE);
        dbg_state = state;
    end

    // Sweep pointer starts at 1: register 0 is hardwired and never needs clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt <= '0;
        else if (idle && clr_req) cnt <= AW'(1);
        else if (sweep)           cnt <= cnt + AW'(1);
    end

    assign wr0 = idle && we0 && (waddr0 != '0);
    assign wr1 = idle && we1 && (waddr1 != '0);

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (sweep) begin
            regs[cnt] <= '0;
        end else begin
            if (wr0) regs[waddr0] <= wdata0;
            if (wr1) regs[waddr1] <= wdata1;
        end
    end

    // A new producer issued in the same cycle as a write-back keeps the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (sweep) begin
            busy[cnt] <= 1'b0;
        end else if (idle) begin
            if (wr0) busy[waddr0] <= 1'b0;
            if (wr1) busy[waddr1] <= 1'b0;
            if (sb_set && (sb_addr != '0)) busy[sb_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          on, hit0, hit1;

        assign ra   = raddr[i*AW +: AW];
        assign on   = !rst && re[i] && (ra != '0);
        assign hit1 = idle && we1 && (waddr1 == ra);
        assign hit0 = idle && we0 && (waddr0 == ra);

        assign rdata[i*DW +: DW] = !on  ? '0     :
                                   hit1 ? wdata1 :
                                   hit0 ? wdata0 : regs[ra];
        assign rbusy[i] = on && busy[ra] && !hit1 && !hit0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, randomized traffic against a
// behavioural model, and hand-written bulk-clear and mid-sweep reset sequences.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic             clk;
    logic             rst;
    logic             we0, we1;
    logic [AW-1:0]    waddr0, waddr1;
    logic [DW-1:0]    wdata0, wdata1;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             clr_req;
    logic             clr_busy, clr_done;
    logic [1:0]       dbg_state;

    regfile_mp #(.DW(DW), .AW(AW), .NR(NR)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];
    int            m_sweep_left;
    bit            m_done;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_idle();
        return (m_sweep_left == 0) && !m_done;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int p);
        logic [AW-1:0] a;
        a = raddr[p*AW +: AW];
        if (rst || !re[p] || a == 0) return '0;
        if (m_idle() && we1 && waddr1 == a) return wdata1;
        if (m_idle() && we0 && waddr0 == a) return wdata0;
        return m_regs[a];
    endfunction

    function automatic logic exp_rb(input int p);
        logic [AW-1:0] a;
        bit written;
        a = raddr[p*AW +: AW];
        if (rst || !re[p] || a == 0) return 1'b0;
        written = m_idle() && ((we1 && waddr1 == a) || (we0 && waddr0 == a));
        return m_busy[a] && !written;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_sweep_left = 0;
        m_done = 1'b0;
    endtask

    // Advances the model by one rising edge using the inputs currently driven.
    task automatic model_clock();
        if (m_sweep_left > 0) begin
            m_regs[DEPTH - m_sweep_left] = '0;
            m_busy[DEPTH - m_sweep_left] = 1'b0;
            m_sweep_left--;
            if (m_sweep_left == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else begin
            if (we0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
            if (clr_req) m_sweep_left = DEPTH - 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NR; p++) begin
            check($sformatf("%s rdata%0d", tag, p), rdata[p*DW +: DW], exp_rd(p));
            check($sformatf("%s rbusy%0d", tag, p), DW'(rbusy[p]), DW'(exp_rb(p)));
        end
        check({tag, " clr_busy"}, DW'(clr_busy), DW'(m_sweep_left > 0));
        check({tag, " clr_done"}, DW'(clr_done), DW'(m_done));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        re = '0; raddr = '0;
        sb_set = 1'b0; sb_addr = '0; clr_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic run_cycle(input string tag);
        #4;
        check_outputs(tag);
        tick();
    endtask

    task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_inputs();
        we0 = 1'b1; waddr0 = a; wdata0 = d;
        re = 2'b11; raddr = {a, a};
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic [NR-1:0] re;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic          sb;
        logic [AW-1:0] sba;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [NR-1:0] eb;
    } vec_t;

    localparam int NT = 18;
    vec_t tbl [NT];

    int busy_cnt, done_cnt;
    bit saw_done;

    initial begin
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        tbl[2]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 2'b00};
        tbl[4]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h22,       32'h22,       2'b00};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd7, 5'd5, 1'b0, 5'd0, 32'h22,       32'hDEADBEEF, 2'b00};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd3, 5'd3, 1'b1, 5'd3, 32'h0,        32'h0,        2'b00};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b01, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0,        32'h0,        2'b01};
        tbl[8]  = '{1'b1, 5'd3, 32'h55,       1'b0, 5'd0, 32'h0,  2'b11, 5'd3, 5'd3, 1'b0, 5'd0, 32'h55,       32'h55,       2'b00};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd3, 5'd3, 1'b0, 5'd0, 32'h55,       32'h55,       2'b00};
        tbl[10] = '{1'b1, 5'd4, 32'h66,       1'b0, 5'd0, 32'h0,  2'b11, 5'd4, 5'd4, 1'b1, 5'd4, 32'h66,       32'h66,       2'b00};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd4, 5'd4, 1'b0, 5'd0, 32'h66,       32'h66,       2'b11};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0,        32'h0,        2'b00};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd0, 5'd4, 1'b0, 5'd0, 32'h0,        32'h66,       2'b10};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h77, 2'b11, 5'd4, 5'd4, 1'b0, 5'd0, 32'h77,       32'h77,       2'b00};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd4, 5'd4, 1'b0, 5'd0, 32'h77,       32'h77,       2'b00};
        tbl[16] = '{1'b1, 5'd4, 32'h88,       1'b1, 5'd9, 32'h99, 2'b11, 5'd4, 5'd9, 1'b0, 5'd0, 32'h88,       32'h99,       2'b00};
        tbl[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  2'b11, 5'd4, 5'd9, 1'b0, 5'd0, 32'h88,       32'h99,       2'b00};

        // reset: outputs forced low even with a matching bypass write presented
        rst = 1'b1;
        idle_inputs();
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hCAFE;
        re = 2'b11; raddr = {5'd5, 5'd5};
        model_reset();
        #3;
        check("reset rdata0", rdata[0 +: DW], '0);
        check("reset rdata1", rdata[DW +: DW], '0);
        check("reset rbusy", DW'(rbusy), '0);
        check("reset clr_busy", DW'(clr_busy), '0);
        check("reset clr_done", DW'(clr_done), '0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        tick();

        re = 2'b11; raddr = {5'd31, 5'd5};
        #4;
        check("post-reset rdata0", rdata[0 +: DW], '0);
        check("post-reset rdata1", rdata[DW +: DW], '0);
        tick();

        for (int i = 0; i < NT; i++) begin
            idle_inputs();
            we0 = tbl[i].we0; waddr0 = tbl[i].wa0; wdata0 = tbl[i].wd0;
            we1 = tbl[i].we1; waddr1 = tbl[i].wa1; wdata1 = tbl[i].wd1;
            re = tbl[i].re; raddr = {tbl[i].ra1, tbl[i].ra0};
            sb_set = tbl[i].sb; sb_addr = tbl[i].sba;
            #4;
            check($sformatf("tbl[%0d] rdata0", i), rdata[0 +: DW], tbl[i].e0);
            check($sformatf("tbl[%0d] rdata1", i), rdata[DW +: DW], tbl[i].e1);
            check($sformatf("tbl[%0d] rbusy", i), DW'(rbusy), DW'(tbl[i].eb));
            tick();
        end

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            idle_inputs();
            we0 = 1'($urandom_range(0, 1));
            waddr0 = AW'($urandom_range(0, 7));
            wdata0 = $urandom;
            we1 = 1'($urandom_range(0, 1));
            waddr1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            wdata1 = $urandom;
            re = NR'($urandom_range(0, 3));
            raddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            sb_set = 1'($urandom_range(0, 1));
            sb_addr = AW'($urandom_range(0, 7));
            clr_req = ($urandom_range(0, 79) == 0);
            run_cycle("rnd");
        end

        idle_inputs();
        for (int k = 0; k < 40 && !m_idle(); k++) run_cycle("drain");

        // bulk clear: fill with index values, mark one busy, sweep under write traffic
        for (int a = 1; a < DEPTH; a++) begin
            write0(AW'(a), DW'(a));
            run_cycle("fill");
        end
        idle_inputs();
        sb_set = 1'b1; sb_addr = 5'd9;
        run_cycle("sb x9");
        idle_inputs();
        re = 2'b11; raddr = {5'd17, 5'd9};
        #4;
        check("pre-clear rdata x9", rdata[0 +: DW], 32'd9);
        check("pre-clear rbusy x9", DW'(rbusy[0]), 32'd1);
        check("pre-clear rdata x17", rdata[DW +: DW], 32'd17);
        tick();

        idle_inputs();
        clr_req = 1'b1;
        run_cycle("clr_req");
        busy_cnt = 0; done_cnt = 0; saw_done = 1'b0;
        for (int k = 0; k < 40 && !saw_done; k++) begin
            idle_inputs();
            we0 = 1'b1; waddr0 = AW'($urandom_range(1, 31)); wdata0 = $urandom;
            we1 = 1'b1; waddr1 = AW'($urandom_range(1, 31)); wdata1 = $urandom;
            sb_set = 1'b1; sb_addr = AW'($urandom_range(1, 31));
            clr_req = 1'($urandom_range(0, 1));
            re = 2'b11; raddr = {waddr1, waddr0};
            #4;
            check_outputs("sweep");
            if (clr_busy) busy_cnt++;
            if (clr_done) begin done_cnt++; saw_done = 1'b1; end
            tick();
        end
        if (!saw_done) check("clr_done timeout", 32'd0, 32'd1);
        check("clr_busy cycles", DW'(busy_cnt), DW'(DEPTH - 1));
        check("clr_done pulses", DW'(done_cnt), 32'd1);

        idle_inputs();
        #4;
        check("after done clr_done", DW'(clr_done), 32'd0);
        check("after done clr_busy", DW'(clr_busy), 32'd0);
        tick();
        for (int a = 0; a < DEPTH; a += 2) begin
            idle_inputs();
            re = 2'b11; raddr = {AW'(a + 1), AW'(a)};
            #4;
            check($sformatf("cleared x%0d", a), rdata[0 +: DW], '0);
            check($sformatf("cleared x%0d", a + 1), rdata[DW +: DW], '0);
            check($sformatf("cleared rbusy x%0d", a), DW'(rbusy), '0);
            tick();
        end
        write0(5'd6, 32'hA5);
        run_cycle("post-clear write");
        idle_inputs();
        re = 2'b01; raddr = {5'd0, 5'd6};
        #4;
        check("post-clear read x6", rdata[0 +: DW], 32'hA5);
        tick();

        // asynchronous reset in the middle of a sweep
        write0(5'd10, 32'h10AA);
        run_cycle("fill x10");
        write0(5'd20, 32'h20BB);
        run_cycle("fill x20");
        idle_inputs();
        clr_req = 1'b1;
        run_cycle("clr_req 2");
        idle_inputs();
        for (int k = 0; k < 5; k++) run_cycle("sweep2");
        re = 2'b11; raddr = {5'd10, 5'd20};
        we1 = 1'b1; waddr1 = 5'd20; wdata1 = 32'hBAD;
        #2;
        check("mid-sweep clr_busy", DW'(clr_busy), 32'd1);
        check("mid-sweep no bypass x20", rdata[0 +: DW], 32'h20BB);
        rst = 1'b1;
        #1;
        check("async rst clr_busy", DW'(clr_busy), '0);
        check("async rst clr_done", DW'(clr_done), '0);
        check("async rst rdata0", rdata[0 +: DW], '0);
        check("async rst rdata1", rdata[DW +: DW], '0);
        check("async rst rbusy", DW'(rbusy), '0);
        model_reset();
        #1;
        we1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        write0(5'd10, 32'h99);
        run_cycle("post-rst write");
        idle_inputs();
        re = 2'b11; raddr = {5'd20, 5'd10};
        #4;
        check("post-rst read x10", rdata[0 +: DW], 32'h99);
        check("post-rst read x20", rdata[DW +: DW], '0);
        check("post-rst clr_busy", DW'(clr_busy), '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
